// File: rtl/sobel_window_gen.sv
// Raster pixel stream to 3x3 Sobel neighbourhood taps using two line buffers and a register window.
// Taps are registered one cycle after the producing accept; there is no backpressure, so every window is taken.
module sobel_window_gen #(
  parameter int PIXEL_W     = 8,
  parameter int LINE_WIDTH  = 64,
  parameter int FRAME_LINES = 48
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [PIXEL_W-1:0] pixel_in,
  input  logic               pixel_valid,
  input  logic               frame_start,
  output logic [PIXEL_W-1:0] pixel_pp,
  output logic [PIXEL_W-1:0] pixel_p0,
  output logic [PIXEL_W-1:0] pixel_pm,
  output logic [PIXEL_W-1:0] pixel_0p,
  output logic [PIXEL_W-1:0] pixel_0m,
  output logic [PIXEL_W-1:0] pixel_mp,
  output logic [PIXEL_W-1:0] pixel_m0,
  output logic [PIXEL_W-1:0] pixel_mm,
  output logic               window_valid,
  output logic               on_edge,
  output logic               frame_done,
  output logic               frame_abort
);

  localparam int CW = $clog2(LINE_WIDTH);
  localparam int RW = $clog2(FRAME_LINES);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_LINES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]      col, cur_col;
  logic [RW-1:0]      row, cur_row;
  logic               started;
  logic               accept, win_hit, col_last, row_last, top, left;
  logic [PIXEL_W-1:0] lb0 [LINE_WIDTH];
  logic [PIXEL_W-1:0] lb1 [LINE_WIDTH];
  logic [PIXEL_W-1:0] lb0_rd, lb1_rd;
  // Index 0 = row r, 1 = row r-1, 2 = row r-2; w0 is column c-1, w1 is column c-2.
  logic [PIXEL_W-1:0] w0 [3];
  logic [PIXEL_W-1:0] w1 [3];

  always_comb begin
    accept   = pixel_valid && (frame_start || state == ACTIVE);
    cur_col  = frame_start ? '0 : col;
    cur_row  = frame_start ? '0 : row;
    col_last = (cur_col == COL_LAST);
    row_last = (cur_row == ROW_LAST);
    top      = (cur_row == RW'(1));
    left     = (cur_col == CW'(1));
    win_hit  = accept && (cur_row != '0) && (cur_col != '0);
    lb0_rd   = lb0[cur_col];
    lb1_rd   = lb1[cur_col];
  end

  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      state_nxt = ACTIVE;
    end else if (state == ACTIVE && accept && col_last && row_last) begin
      state_nxt = DONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col     <= '0;
      row     <= '0;
      started <= 1'b0;
    end else begin
      if (accept) begin
        col <= col_last ? '0 : cur_col + CW'(1);
        row <= col_last ? (row_last ? '0 : cur_row + RW'(1)) : cur_row;
      end else if (frame_start) begin
        col <= '0;
        row <= '0;
      end
      if (frame_start) begin
        started <= accept;
      end else if (accept) begin
        started <= 1'b1;
      end
    end
  end

  // Read-before-write: the reads above see the old contents in the accepting cycle.
  always_ff @(posedge clock) begin
    if (accept) begin
      lb1[cur_col] <= lb0_rd;
      lb0[cur_col] <= pixel_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w0 <= '{default: '0};
      w1 <= '{default: '0};
    end else if (accept) begin
      w0[0] <= pixel_in;
      w0[1] <= lb0_rd;
      w0[2] <= lb1_rd;
      w1    <= w0;
    end
  end

  // Taps above row 0 or left of column 0 come from stale storage and are forced to 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pixel_pp     <= '0;
      pixel_p0     <= '0;
      pixel_pm     <= '0;
      pixel_0p     <= '0;
      pixel_0m     <= '0;
      pixel_mp     <= '0;
      pixel_m0     <= '0;
      pixel_mm     <= '0;
      window_valid <= 1'b0;
      on_edge      <= 1'b0;
      frame_done   <= 1'b0;
      frame_abort  <= 1'b0;
    end else begin
      window_valid <= win_hit;
      frame_done   <= win_hit && col_last && row_last;
      frame_abort  <= frame_start && (state == ACTIVE) && started;
      if (win_hit) begin
        pixel_pp <= pixel_in;
        pixel_p0 <= lb0_rd;
        pixel_pm <= top ? '0 : lb1_rd;
        pixel_0p <= w0[0];
        pixel_0m <= top ? '0 : w0[2];
        pixel_mp <= left ? '0 : w1[0];
        pixel_m0 <= left ? '0 : w1[1];
        pixel_mm <= (top || left) ? '0 : w1[2];
        on_edge  <= top || left;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on a 4x3 frame whose pixel at (row,col) is 16*row+col.
module tb_sobel_window_gen;

  localparam int PW = 8;
  localparam int LW = 4;
  localparam int FL = 3;

  typedef logic [65:0] win_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [PW-1:0] pixel_in;
  logic          pixel_valid;
  logic          frame_start;
  logic [PW-1:0] pixel_pp, pixel_p0, pixel_pm, pixel_0p, pixel_0m, pixel_mp, pixel_m0, pixel_mm;
  logic          window_valid, on_edge, frame_done, frame_abort;

  win_t exp_q[$];
  win_t exp_tab [6];
  int   checks = 0;
  int   errors = 0;
  int   aborts_seen = 0;

  sobel_window_gen #(.PIXEL_W(PW), .LINE_WIDTH(LW), .FRAME_LINES(FL)) dut (
    .clock(clock), .reset_n(reset_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .pixel_pp(pixel_pp), .pixel_p0(pixel_p0), .pixel_pm(pixel_pm),
    .pixel_0p(pixel_0p), .pixel_0m(pixel_0m), .pixel_mp(pixel_mp), .pixel_m0(pixel_m0),
    .pixel_mm(pixel_mm), .window_valid(window_valid), .on_edge(on_edge),
    .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] taps();
    return {pixel_pp, pixel_p0, pixel_pm, pixel_0p, pixel_0m, pixel_mp, pixel_m0, pixel_mm};
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected window whenever the DUT presents one.
  always @(negedge clock) begin
    win_t e;
    if (window_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: got window_valid=1 taps=%h, expected no window", taps());
      end else begin
        e = exp_q.pop_front();
        check("window", 80'({taps(), on_edge, frame_done}), 80'(e));
      end
    end else if (frame_done) begin
      checks++;
      errors++;
      $display("FAIL done_without_window: got frame_done=1 window_valid=0, expected frame_done=0");
    end
    if (frame_abort) aborts_seen++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_pixel(input int r, input int c, input bit fs, input bit exp_win);
    pixel_in    = PW'(16 * r + c);
    pixel_valid = 1'b1;
    frame_start = fs;
    if (exp_win) exp_q.push_back(exp_tab[(r - 1) * (LW - 1) + (c - 1)]);
    tick();
    pixel_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send_frame(input bit fs_first, input bit gaps, input bit windows);
    for (int r = 0; r < FL; r++) begin
      for (int c = 0; c < LW; c++) begin
        send_pixel(r, c, fs_first && r == 0 && c == 0, windows && r >= 1 && c >= 1);
        if (gaps) repeat ($urandom_range(0, 3)) tick();
      end
    end
  endtask

  task automatic fs_only(input bit exp_abort, input string name);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clock);
    check(name, 80'(frame_abort), 80'(exp_abort));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // {pp,p0,pm,0p,0m,mp,m0,mm,on_edge,frame_done} for centres (0,0..2),(1,0..2)
    exp_tab[0] = {8'h11, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    exp_tab[1] = {8'h12, 8'h02, 8'h00, 8'h11, 8'h00, 8'h10, 8'h00, 8'h00, 1'b1, 1'b0};
    exp_tab[2] = {8'h13, 8'h03, 8'h00, 8'h12, 8'h00, 8'h11, 8'h01, 8'h00, 1'b1, 1'b0};
    exp_tab[3] = {8'h21, 8'h11, 8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    exp_tab[4] = {8'h22, 8'h12, 8'h02, 8'h21, 8'h01, 8'h20, 8'h10, 8'h00, 1'b0, 1'b0};
    exp_tab[5] = {8'h23, 8'h13, 8'h03, 8'h22, 8'h02, 8'h21, 8'h11, 8'h01, 1'b0, 1'b1};

    reset_n     = 1'b0;
    pixel_in    = '0;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", 80'({taps(), window_valid, on_edge, frame_done, frame_abort}), 80'(0));
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) send_pixel(0, i, 1'b0, 1'b0);  // IDLE: dropped
    send_frame(1'b1, 1'b0, 1'b1);                              // continuous frame
    for (int i = 0; i < 5; i++) send_pixel(0, i, 1'b0, 1'b0);  // DONE: dropped

    fs_only(1'b0, "no_abort_from_done");
    send_frame(1'b0, 1'b1, 1'b1);                              // frame with idle gaps

    send_pixel(0, 0, 1'b1, 1'b0);
    for (int c = 1; c < LW; c++) send_pixel(0, c, 1'b0, 1'b0);
    send_pixel(1, 0, 1'b0, 1'b0);
    fs_only(1'b1, "abort_mid_frame");
    fs_only(1'b0, "no_abort_without_pixels");
    send_frame(1'b0, 1'b0, 1'b1);

    fs_only(1'b0, "no_abort_after_frame");
    for (int c = 0; c < LW; c++) send_pixel(0, c, 1'b0, 1'b0);
    send_pixel(1, 0, 1'b0, 1'b0);
    send_pixel(1, 1, 1'b0, 1'b1);
    send_pixel(1, 2, 1'b0, 1'b1);
    send_pixel(1, 3, 1'b0, 1'b1);
    #5;
    reset_n = 1'b0;
    #1;
    check("async_reset_valid", 80'(window_valid), 80'(0));
    check("async_reset_taps", 80'({taps(), on_edge, frame_done, frame_abort}), 80'(0));
    tick();
    reset_n = 1'b1;
    tick();

    send_frame(1'b0, 1'b0, 1'b0);                              // no frame_start: no windows
    send_frame(1'b1, 1'b0, 1'b1);

    repeat (4) tick();
    check("queue_drained", 80'(exp_q.size()), 80'(0));
    check("abort_count", 80'(aborts_seen), 80'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
